// File: rtl/oam_dma_controller_pkg.sv
// Shared types and address constants for the OAM DMA engine.
// Build option: OAM_DMA_SRC_MIRROR_EN folds source pages $E0-$FF onto $C0-$DF.
package oam_dma_controller_pkg;

  localparam logic [15:0] OAM_start    = 16'hFE00;
  localparam logic [15:0] DMA_OAM_addr = 16'hFF46;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_START,
    DMA_XFER
  } dma_state_t;

  localparam int unsigned DMA_PHASE_READ  = 0;
  localparam int unsigned DMA_PHASE_WRITE = 1;

  // Page actually fetched from; echo RAM pages alias onto WRAM when mirroring is built in.
  function automatic logic [7:0] dma_src_page(input logic [7:0] page);
`ifdef OAM_DMA_SRC_MIRROR_EN
    return (page >= 8'hE0) ? (page - 8'h20) : page;
`else
    return page;
`endif
  endfunction

endpackage

// File: rtl/oam_dma_controller.sv
// OAM DMA engine behind $FF46: copies LENGTH bytes from {page,8'h00} to $FE00.
// Build option: OAM_DMA_SRC_MIRROR_EN (see oam_dma_controller_pkg::dma_src_page).
module oam_dma_controller
  import oam_dma_controller_pkg::*;
#(
  parameter int unsigned LENGTH          = 160,
  parameter int unsigned CYCLES_PER_BYTE = 4,
  parameter int unsigned START_DELAY     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] reg_addr,
  input  logic [7:0]  reg_wdata,
  input  logic        reg_read_en,
  input  logic        reg_write_en,
  output logic [7:0]  reg_rdata,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic        dma_read_en,
  output logic        dma_write_en,
  output logic [7:0]  dma_wdata,
  input  logic [7:0]  dma_rdata
);

  localparam int unsigned PH_W  = $clog2(CYCLES_PER_BYTE);
  localparam int unsigned DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(CYCLES_PER_BYTE - 1);
  localparam logic [PH_W-1:0]  PH_READ   = PH_W'(DMA_PHASE_READ);
  localparam logic [PH_W-1:0]  PH_WRITE  = PH_W'(DMA_PHASE_WRITE);
  localparam logic [DLY_W-1:0] DLY_LAST  = DLY_W'(START_DELAY - 1);
  localparam logic [7:0]       IDX_LAST  = 8'(LENGTH - 1);

  dma_state_t       state_q, state_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [7:0]       idx_q, idx_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [7:0]       page_q, page_d;
  logic             hold_q, hold_d;
  logic             active_q, active_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;

  // Register address is pre-decoded and reads have no side effects.
  logic unused_reg_bus;
  assign unused_reg_bus = (reg_addr == DMA_OAM_addr) ^ reg_read_en;

  // State register and registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= DMA_IDLE;
      dly_q    <= '0;
      idx_q    <= '0;
      phase_q  <= '0;
      page_q   <= 8'hFF;
      hold_q   <= 1'b0;
      active_q <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= 16'h0000;
      wdata_q  <= 8'hFF;
    end else begin
      state_q  <= state_d;
      dly_q    <= dly_d;
      idx_q    <= idx_d;
      phase_q  <= phase_d;
      page_q   <= page_d;
      hold_q   <= hold_d;
      active_q <= active_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Next-state sequencing; outputs are decoded from the next state so they land with it.
  always_comb begin
    state_d  = state_q;
    dly_d    = dly_q;
    idx_d    = idx_q;
    phase_d  = phase_q;
    page_d   = page_q;
    hold_d   = hold_q;
    active_d = 1'b0;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;

    unique case (state_q)
      DMA_IDLE: begin
        if (reg_write_en) begin
          state_d = DMA_START;
          dly_d   = '0;
          hold_d  = 1'b0;
          page_d  = reg_wdata;
        end
      end
      DMA_START: begin
        if (dly_q == DLY_LAST) begin
          state_d = DMA_XFER;
          idx_d   = 8'h00;
          phase_d = '0;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end
      DMA_XFER: begin
        if (phase_q == PH_LAST) begin
          if (idx_q == IDX_LAST) begin
            state_d = DMA_IDLE;
          end else begin
            idx_d   = idx_q + 8'd1;
            phase_d = '0;
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      default: state_d = DMA_IDLE;
    endcase

    // A write while busy restarts the copy and keeps the bus claimed.
    if (reg_write_en && (state_q != DMA_IDLE)) begin
      state_d = DMA_START;
      dly_d   = '0;
      idx_d   = 8'h00;
      phase_d = '0;
      hold_d  = 1'b1;
      page_d  = reg_wdata;
    end

    active_d = (state_d == DMA_XFER) || ((state_d == DMA_START) && hold_d);
    rd_d     = (state_d == DMA_XFER) && (phase_d == PH_READ);
    wr_d     = (state_d == DMA_XFER) && (phase_d == PH_WRITE);

    if (rd_d) begin
      addr_d = {dma_src_page(page_d), 8'h00} | {8'h00, idx_d};
    end else if (wr_d) begin
      addr_d = OAM_start + {8'h00, idx_d};
    end

    // Source data is valid during the read strobe; capture it for the following write.
    if (rd_q) begin
      wdata_d = dma_rdata;
    end
  end

  assign reg_rdata    = page_q;
  assign dma_active   = active_q;
  assign dma_read_en  = rd_q;
  assign dma_write_en = wr_q;
  assign dma_addr     = addr_q;
  assign dma_wdata    = wdata_q;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Scoreboard bench for oam_dma_controller: stimulus queues expected bus strobes, a monitor pops them.
`timescale 1ns/1ps
module tb_oam_dma_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_read_en;
  logic        reg_write_en;
  logic [7:0]  reg_rdata;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic        dma_read_en;
  logic        dma_write_en;
  logic [7:0]  dma_wdata;
  logic [7:0]  dma_rdata;

  logic [7:0]  src_mem [0:65535];
  logic [7:0]  oam_mem [0:159];
  logic [15:0] rd_q [$];
  logic [23:0] wr_q [$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;

  oam_dma_controller dut (
    .clk          (clk),
    .reset        (reset),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_read_en  (reg_read_en),
    .reg_write_en (reg_write_en),
    .reg_rdata    (reg_rdata),
    .dma_active   (dma_active),
    .dma_addr     (dma_addr),
    .dma_read_en  (dma_read_en),
    .dma_write_en (dma_write_en),
    .dma_wdata    (dma_wdata),
    .dma_rdata    (dma_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign dma_rdata = dma_read_en ? src_mem[dma_addr] : 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the head of its expectation queue.
  always @(negedge clk) begin
    if (!reset && (dma_read_en || dma_write_en)) begin
      check("strobe_exclusive", 32'(dma_read_en & dma_write_en), 32'd0);
      if (dma_read_en) begin
        if (rd_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_read: got addr %h, required no read", dma_addr);
        end else begin
          check("read_addr", 32'(dma_addr), 32'(rd_q.pop_front()));
        end
      end
      if (dma_write_en) begin
        if (wr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %h data %h, required no write", dma_addr, dma_wdata);
        end else begin
          logic [23:0] e;
          e = wr_q.pop_front();
          check("write_addr", 32'(dma_addr), 32'(e[23:8]));
          check("write_data", 32'(dma_wdata), 32'(e[7:0]));
        end
        if (dma_addr >= 16'hFE00 && dma_addr < 16'hFEA0)
          oam_mem[dma_addr - 16'hFE00] = dma_wdata;
      end
    end
  end

  // Queue the reads and writes one copy from src_base should produce.
  task automatic push_xfer(input logic [15:0] src_base, input int n_rd, input int n_wr);
    for (int i = 0; i < n_rd; i++) rd_q.push_back(src_base + 16'(i));
    for (int i = 0; i < n_wr; i++)
      wr_q.push_back({16'hFE00 + 16'(i), src_mem[src_base + 16'(i)]});
  endtask

  // Write sampled at the next posedge; t0 marks that edge.
  task automatic cpu_write(input logic [7:0] v);
    reg_addr     = 16'hFF46;
    reg_wdata    = v;
    reg_write_en = 1'b1;
    @(posedge clk);
    #1;
    reg_write_en = 1'b0;
    t0 = cyc;
  endtask

  task automatic cpu_read_check(input string name, input logic [7:0] exp);
    reg_read_en = 1'b1;
    check(name, 32'(reg_rdata), 32'(exp));
    @(posedge clk);
    #1;
    reg_read_en = 1'b0;
  endtask

  // Advance to just after edge n relative to the last write edge.
  task automatic wait_to(input int n);
    while (cyc < t0 + n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_oam();
    for (int i = 0; i < 160; i++) oam_mem[i] = 8'h00;
  endtask

  task automatic check_oam(input logic [15:0] src_base, input int n);
    int errs;
    errs = 0;
    for (int i = 0; i < n; i++)
      if (oam_mem[i] !== src_mem[src_base + 16'(i)]) errs++;
    check("oam_final_mismatches", 32'(errs), 32'd0);
  endtask

  task automatic check_drained(input string name);
    check({name, "_rd_left"}, 32'(rd_q.size()), 32'd0);
    check({name, "_wr_left"}, 32'(wr_q.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] mirror_base;
    for (int a = 0; a < 65536; a++) src_mem[a] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      src_mem[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;
      src_mem[16'hC100 + 16'(i)] = 8'(i * 7 + 3);
      src_mem[16'hE000 + 16'(i)] = ~8'(i);
    end
    clear_oam();
    reset = 1'b1; reg_addr = 16'hFF46; reg_wdata = 8'h00;
    reg_read_en = 1'b0; reg_write_en = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_active",   32'(dma_active),   32'd0);
    check("rst_read_en",  32'(dma_read_en),  32'd0);
    check("rst_write_en", 32'(dma_write_en), 32'd0);
    check("rst_addr",     32'(dma_addr),     32'h0000);
    check("rst_wdata",    32'(dma_wdata),    32'hFF);
    check("rst_reg_rdata",32'(reg_rdata),    32'hFF);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Basic copy from $C0 with readback at clk 0, 300 and 700
    clear_oam();
    push_xfer(16'hC000, 160, 160);
    cpu_write(8'hC0);
    cpu_read_check("readback_clk0", 8'hC0);
    wait_to(3);
    check("basic_active_before_start", 32'(dma_active), 32'd0);
    wait_to(4);
    check("basic_active_rise", 32'(dma_active), 32'd1);
    check("basic_first_addr",  32'(dma_addr),   32'hC000);
    wait_to(300);
    cpu_read_check("readback_clk300", 8'hC0);
    wait_to(643);
    check("basic_active_last", 32'(dma_active), 32'd1);
    wait_to(644);
    check("basic_active_fall", 32'(dma_active), 32'd0);
    wait_to(700);
    cpu_read_check("readback_clk700", 8'hC0);
    check_oam(16'hC000, 160);
    check_drained("basic");

    // Restart at byte 50 with page $C1
    clear_oam();
    push_xfer(16'hC000, 51, 50);
    push_xfer(16'hC100, 160, 160);
    cpu_write(8'hC0);
    wait_to(204);
    cpu_write(8'hC1);
    check("restart_active_held", 32'(dma_active), 32'd1);
    wait_to(3);
    check("restart_active_start", 32'(dma_active), 32'd1);
    wait_to(4);
    check("restart_first_addr", 32'(dma_addr), 32'hC100);
    wait_to(644);
    check("restart_active_fall", 32'(dma_active), 32'd0);
    check_oam(16'hC100, 160);
    check_drained("restart");
    cpu_read_check("restart_readback", 8'hC1);

    // Write in the final cycle of the last byte restarts instead of idling
    clear_oam();
    push_xfer(16'hC000, 160, 160);
    push_xfer(16'hC100, 160, 160);
    cpu_write(8'hC0);
    wait_to(643);
    cpu_write(8'hC1);
    check("lastcyc_active_held", 32'(dma_active), 32'd1);
    wait_to(4);
    check("lastcyc_first_addr", 32'(dma_addr), 32'hC100);
    wait_to(643);
    check("lastcyc_active_last", 32'(dma_active), 32'd1);
    wait_to(644);
    check("lastcyc_active_fall", 32'(dma_active), 32'd0);
    check_oam(16'hC100, 160);
    check_drained("lastcyc");

    // Reset taking effect at the start of byte 80
    clear_oam();
    push_xfer(16'hC000, 80, 80);
    cpu_write(8'hC0);
    wait_to(323);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_active",    32'(dma_active),   32'd0);
    check("midrst_read_en",   32'(dma_read_en),  32'd0);
    check("midrst_write_en",  32'(dma_write_en), 32'd0);
    check("midrst_reg_rdata", 32'(reg_rdata),    32'hFF);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_oam(16'hC000, 80);
    check_drained("midrst");

    // Echo-RAM source page
`ifdef OAM_DMA_SRC_MIRROR_EN
    mirror_base = 16'hC000;
`else
    mirror_base = 16'hE000;
`endif
    clear_oam();
    push_xfer(mirror_base, 160, 160);
    cpu_write(8'hE0);
    check("mirror_readback", 32'(reg_rdata), 32'hE0);
    wait_to(4);
    check("mirror_first_addr", 32'(dma_addr), 32'(mirror_base));
    wait_to(644);
    check("mirror_active_fall", 32'(dma_active), 32'd0);
    check_oam(mirror_base, 160);
    check_drained("mirror");

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
